// File: rtl/edge_capture.sv
// Multi-channel edge capture for asynchronous inputs: synchroniser, programmable
// glitch filter, registered edge pulses, sticky write-one-to-clear flags and irq.
module edge_capture #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_BITS   = 4
) (
    input  logic                 rst,
    input  logic                 clk,
    input  logic                 ce,
    input  logic [WIDTH-1:0]     i,
    input  logic [FILT_BITS-1:0] filt_len,
    input  logic [WIDTH-1:0]     pe_en,
    input  logic [WIDTH-1:0]     ne_en,
    input  logic [WIDTH-1:0]     ack,
    output logic [WIDTH-1:0]     level,
    output logic [WIDTH-1:0]     pe,
    output logic [WIDTH-1:0]     ne,
    output logic [WIDTH-1:0]     ee,
    output logic [WIDTH-1:0]     flag,
    output logic                 irq
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync;
    logic [WIDTH-1:0]                  s;
    logic [WIDTH-1:0]                  q;
    logic [WIDTH-1:0]                  commit;
    logic [WIDTH-1:0][FILT_BITS-1:0]   cnt;
    logic [WIDTH-1:0][FILT_BITS-1:0]   cnt_next;

    assign s = sync[SYNC_STAGES-1];

    // The synchroniser follows the pins on every clk, even while ce is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= '0;
        else     sync <= {sync[SYNC_STAGES-2:0], i};
    end

    always_comb begin
        // NOTE: defaults first so every path assigns commit and cnt_next (no latch).
        commit   = '0;
        cnt_next = cnt;
        if (ce) begin
            for (int c = 0; c < WIDTH; c++) begin
                if (s[c] == q[c]) begin
                    cnt_next[c] = '0;
                end else if (cnt[c] >= filt_len) begin
                    commit[c]   = 1'b1;
                    cnt_next[c] = '0;
                end else if (cnt[c] != '1) begin
                    cnt_next[c] = cnt[c] + FILT_BITS'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= '0;
            cnt  <= '0;
            pe   <= '0;
            ne   <= '0;
            ee   <= '0;
            flag <= '0;
        end else begin
            // NOTE: non-blocking, so flag samples the pe/ne launched on the previous edge.
            q    <= (q & ~commit) | (s & commit);
            cnt  <= cnt_next;
            pe   <= commit & s;
            ne   <= commit & ~s;
            ee   <= commit;
            // A new enabled event outranks an ack landing on the same channel.
            flag <= (flag & ~ack) | (pe & pe_en) | (ne & ne_en);
        end
    end

    assign level = q;
    assign irq   = |flag;

endmodule

// File: tb/tb_edge_capture.sv
// Self-checking bench for edge_capture: scripted vector table, hand-written
// multi-cycle corner cases and a randomized run against a behavioural model.
module tb_edge_capture;

    localparam int W  = 8;
    localparam int SS = 2;
    localparam int FB = 4;

    logic          rst;
    logic          clk;
    logic          ce;
    logic [W-1:0]  i;
    logic [FB-1:0] filt_len;
    logic [W-1:0]  pe_en;
    logic [W-1:0]  ne_en;
    logic [W-1:0]  ack;
    logic [W-1:0]  level;
    logic [W-1:0]  pe;
    logic [W-1:0]  ne;
    logic [W-1:0]  ee;
    logic [W-1:0]  flag;
    logic          irq;

    int n_checks = 0;
    int n_fail   = 0;

    edge_capture #(.WIDTH(W), .SYNC_STAGES(SS), .FILT_BITS(FB)) dut (
        .rst(rst), .clk(clk), .ce(ce), .i(i), .filt_len(filt_len),
        .pe_en(pe_en), .ne_en(ne_en), .ack(ack),
        .level(level), .pe(pe), .ne(ne), .ee(ee), .flag(flag), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock edge; outputs are then sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i   = '0;
        ack = '0;
        ce  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- behavioural reference model ----------------
    logic [W-1:0] hist[$];
    logic [W-1:0] m_level, m_pe, m_ne, m_flag;
    int           run_len[W];

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < SS; k++) hist.push_back('0);
        m_level = '0;
        m_pe    = '0;
        m_ne    = '0;
        m_flag  = '0;
        for (int c = 0; c < W; c++) run_len[c] = 0;
    endtask

    // Advance the model by one clk using the inputs about to be sampled.
    task automatic model_edge();
        logic [W-1:0] s_m;
        logic [W-1:0] com;
        s_m = hist[0];
        hist.push_back(i);
        hist.delete(0);
        com = '0;
        if (ce) begin
            for (int c = 0; c < W; c++) begin
                if (s_m[c] == m_level[c]) begin
                    run_len[c] = 0;
                end else if (run_len[c] + 1 > int'(filt_len)) begin
                    com[c]     = 1'b1;
                    run_len[c] = 0;
                end else begin
                    run_len[c] = run_len[c] + 1;
                end
            end
        end
        m_flag  = (m_flag & ~ack) | (m_pe & pe_en) | (m_ne & ne_en);
        m_pe    = com & s_m;
        m_ne    = com & ~s_m;
        m_level = (m_level & ~com) | (s_m & com);
    endtask

    // ---------------- scripted vector table ----------------
    typedef struct {
        logic [W-1:0] vi;
        logic [W-1:0] vack;
        logic [W-1:0] exp_level;
        logic [W-1:0] exp_pe;
        logic [W-1:0] exp_ne;
        logic [W-1:0] exp_flag;
        logic         exp_irq;
    } vec_t;

    vec_t tbl[18];

    initial begin
        logic [W-1:0] seen_pe, seen_lvl;
        int pe_edge, ne_edge, ee_cnt, both;

        tbl[0]  = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[1]  = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[2]  = '{8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 1'b0};
        tbl[3]  = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 1'b1};
        tbl[4]  = '{8'h03, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 1'b1};
        tbl[5]  = '{8'h03, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 1'b1};
        tbl[6]  = '{8'h03, 8'h00, 8'h03, 8'h02, 8'h00, 8'h01, 1'b1};
        tbl[7]  = '{8'h03, 8'h00, 8'h03, 8'h00, 8'h00, 8'h01, 1'b1};
        tbl[8]  = '{8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h01, 1'b1};
        tbl[9]  = '{8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h01, 1'b1};
        tbl[10] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h01, 1'b1};
        tbl[11] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 1'b1};
        tbl[12] = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1};
        tbl[13] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1};
        tbl[14] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1};
        tbl[15] = '{8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 8'h01, 1'b1};
        tbl[16] = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 1'b1};
        tbl[17] = '{8'h01, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0};

        rst = 1'b1; ce = 1'b1; i = '0; filt_len = '0;
        pe_en = 8'h01; ne_en = 8'h02; ack = '0;
        #1;
        check("reset_level", 32'(level), 32'h0);
        check("reset_flag",  32'(flag),  32'h0);
        check("reset_irq",   32'(irq),   32'h0);

        // Reset, L=0, enables, ack and ack-vs-set priority.
        do_reset();
        check("post_reset_pe", 32'(pe), 32'h0);
        for (int r = 0; r < 18; r++) begin
            i   = tbl[r].vi;
            ack = tbl[r].vack;
            step();
            check($sformatf("tbl%0d_level", r), 32'(level), 32'(tbl[r].exp_level));
            check($sformatf("tbl%0d_pe", r),    32'(pe),    32'(tbl[r].exp_pe));
            check($sformatf("tbl%0d_ne", r),    32'(ne),    32'(tbl[r].exp_ne));
            check($sformatf("tbl%0d_ee", r),    32'(ee),    32'(tbl[r].exp_pe | tbl[r].exp_ne));
            check($sformatf("tbl%0d_flag", r),  32'(flag),  32'(tbl[r].exp_flag));
            check($sformatf("tbl%0d_irq", r),   32'(irq),   32'(tbl[r].exp_irq));
        end
        ack = '0;

        // Glitch rejection, L=3: 3-clk pulse rejected, 4-clk pulse accepted.
        do_reset();
        filt_len = 4'd3; pe_en = 8'hFF; ne_en = 8'hFF;
        seen_pe = '0; seen_lvl = '0;
        for (int k = 1; k <= 12; k++) begin
            i = (k <= 3) ? 8'h04 : 8'h00;
            step();
            seen_pe  = seen_pe | pe;
            seen_lvl = seen_lvl | level;
        end
        check("glitch_no_pe",    32'(seen_pe),  32'h0);
        check("glitch_no_level", 32'(seen_lvl), 32'h0);
        pe_edge = 0; ne_edge = 0; ee_cnt = 0; both = 0;
        for (int k = 1; k <= 16; k++) begin
            i = (k <= 4) ? 8'h04 : 8'h00;
            step();
            if (pe[2] && pe_edge == 0) pe_edge = k;
            if (ne[2] && ne_edge == 0) ne_edge = k;
            if (ee[2]) ee_cnt++;
            if ((pe & ne) != '0) both++;
        end
        check("pulse4_pe_edge", 32'(pe_edge), 32'd6);
        check("pulse4_ne_edge", 32'(ne_edge), 32'd10);
        check("pulse4_ee_count", 32'(ee_cnt), 32'd2);
        check("pulse4_pe_ne_exclusive", 32'(both), 32'd0);
        check("pulse4_flag", 32'(flag), 32'h04);

        // ce gating, L=2, ce high on odd clks only.
        do_reset();
        filt_len = 4'd2;
        pe_edge = 0;
        for (int k = 1; k <= 12; k++) begin
            i  = 8'h20;
            ce = (k % 2 == 1);
            step();
            if (pe[5] && pe_edge == 0) pe_edge = k;
        end
        check("ce_pe_edge", 32'(pe_edge), 32'd7);
        check("ce_level_hi", 32'(level), 32'h20);
        ce = 1'b0; i = 8'h00;
        for (int k = 0; k < 4; k++) step();
        check("ce_frozen_level", 32'(level), 32'h20);
        ce = 1'b1; step();
        ce = 1'b0;
        seen_pe = '0;
        for (int k = 0; k < 5; k++) begin
            step();
            seen_pe = seen_pe | ne;
        end
        check("ce_frozen_no_ne", 32'(seen_pe), 32'h0);
        ce = 1'b1; step();
        check("ce_second_level", 32'(level), 32'h20);
        check("ce_second_ne",    32'(ne),    32'h00);
        step();
        check("ce_third_ne",    32'(ne),    32'h20);
        check("ce_third_level", 32'(level), 32'h00);

        // All channels at once, L=0.
        do_reset();
        filt_len = 4'd0;
        i = 8'hFF;
        step(); step(); step();
        check("multi_pe",    32'(pe),    32'hFF);
        check("multi_level", 32'(level), 32'hFF);
        step();
        check("multi_flag", 32'(flag), 32'hFF);
        check("multi_irq",  32'(irq),  32'h1);
        i = 8'h00;
        step(); step(); step();
        check("multi_ne",       32'(ne), 32'hFF);
        check("multi_pe_clear", 32'(pe), 32'h00);

        // Lower L from 7 to 0 while the count sits at 3.
        filt_len = 4'd7;
        i = 8'h01;
        seen_pe = '0;
        for (int k = 0; k < 5; k++) begin
            step();
            seen_pe = seen_pe | pe;
        end
        check("lchange_no_early_pe", 32'(seen_pe), 32'h0);
        filt_len = 4'd0;
        step();
        check("lchange_pe", 32'(pe), 32'h01);

        // Asynchronous reset mid-count clears everything before the next edge.
        filt_len = 4'd7;
        i = 8'h00;
        step(); step(); step();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_level", 32'(level), 32'h0);
        check("async_rst_flag",  32'(flag),  32'h0);
        check("async_rst_irq",   32'(irq),   32'h0);
        check("async_rst_ee",    32'(ee),    32'h0);

        // Randomized run against the model.
        do_reset();
        model_reset();
        filt_len = 4'd1; pe_en = 8'hFF; ne_en = 8'hFF;
        for (int n = 0; n < 4000; n++) begin
            if (n % 250 == 0) filt_len = FB'($urandom_range(0, 4));
            if (n % 60 == 0) begin
                pe_en = W'($urandom);
                ne_en = W'($urandom);
            end
            i   = i ^ W'($urandom & $urandom & $urandom);
            ce  = ($urandom_range(0, 3) != 0);
            ack = W'($urandom & $urandom & $urandom);
            model_edge();
            step();
            check("rand_level", 32'(level), 32'(m_level));
            check("rand_pe",    32'(pe),    32'(m_pe));
            check("rand_ne",    32'(ne),    32'(m_ne));
            check("rand_ee",    32'(ee),    32'(m_pe | m_ne));
            check("rand_flag",  32'(flag),  32'(m_flag));
            check("rand_irq",   32'(irq),   32'(m_flag != '0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
